// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct values and datapath select codes.
package control_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] DW_ALU = 2'b00;
    localparam logic [1:0] DW_MEM = 2'b01;
    localparam logic [1:0] DW_PC4 = 2'b10;

    localparam logic [1:0] RW_RT  = 2'b00;
    localparam logic [1:0] RW_RD  = 2'b01;
    localparam logic [1:0] RW_R31 = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational (opcode, funct) -> ALU operation, plus the
// legality flag consulted by DECODE.
module alu_decoder
    import control_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                legal
);

    always_comb begin
        alu_op = ALU_OP_W'(ALU_ADD);
        legal  = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                unique case (funct)
                    FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
                    FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
                    FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
                    FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
                    FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
                    default: legal  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL: legal = 1'b1;
            OP_BEQ: begin
                legal  = 1'b1;
                alu_op = ALU_OP_W'(ALU_SUB);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, sticky illegal-opcode trap and retire counter.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int ALU_OP_W  = 4,
    parameter int RET_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 if_ready,
    input  logic                 dm_ready,
    output logic                 if_req,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic [1:0]           next_pc_sel,
    output logic                 seu_en,
    output logic                 alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [1:0]           dw_sel,
    output logic [1:0]           rw_sel,
    output logic                 rf_wr,
    output logic                 dm_rd,
    output logic                 dm_wr,
    output logic                 illegal,
    output logic [RET_CNT_W-1:0] retired
);

    state_t state, next_state;
    logic [5:0] op_q, fn_q;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic dec_legal;
    logic retire;

    alu_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_decoder (
        .opcode (op_q),
        .funct  (fn_q),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            fn_q    <= '0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && if_ready) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (retire) retired <= retired + RET_CNT_W'(1);
        end
    end

    always_comb begin
        next_state  = state;
        if_req      = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        next_pc_sel = PC_PLUS4;
        seu_en      = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = '0;
        dw_sel      = DW_ALU;
        rw_sel      = RW_RT;
        rf_wr       = 1'b0;
        dm_rd       = 1'b0;
        dm_wr       = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ready) begin
                    ir_wr      = 1'b1;
                    pc_wr      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: next_state = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_op = dec_alu_op;
                unique case (op_q)
                    OP_LW, OP_SW: begin
                        seu_en     = 1'b1;
                        alu_src_b  = 1'b1;
                        next_state = S_MEM;
                    end
                    OP_ADDI: begin
                        seu_en     = 1'b1;
                        alu_src_b  = 1'b1;
                        next_state = S_WB;
                    end
                    OP_BEQ: begin
                        pc_wr       = zero;
                        next_pc_sel = PC_BRANCH;
                        retire      = 1'b1;
                        next_state  = S_FETCH;
                    end
                    OP_J: begin
                        pc_wr       = 1'b1;
                        next_pc_sel = PC_JUMP;
                        retire      = 1'b1;
                        next_state  = S_FETCH;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                dm_rd = (op_q == OP_LW);
                dm_wr = (op_q != OP_LW);
                if (dm_ready) begin
                    retire     = (op_q != OP_LW);
                    next_state = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_wr      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
                unique case (op_q)
                    OP_ADDI: rw_sel = RW_RT;
                    OP_LW: begin
                        dw_sel = DW_MEM;
                        rw_sel = RW_RT;
                    end
                    OP_JAL: begin
                        dw_sel      = DW_PC4;
                        rw_sel      = RW_R31;
                        pc_wr       = 1'b1;
                        next_pc_sel = PC_JUMP;
                    end
                    default: rw_sel = RW_RD;
                endcase
            end
            S_TRAP: illegal = 1'b1;
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a
// per-instruction behavioural model of cycles, strobes and selects.
module tb_multicycle_control_unit;

    localparam int AW = 4;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opcode, funct;
    logic zero, if_ready, dm_ready;
    logic if_req, ir_wr, pc_wr, seu_en, alu_src_b;
    logic rf_wr, dm_rd, dm_wr, illegal;
    logic [1:0] next_pc_sel, dw_sel, rw_sel;
    logic [AW-1:0] alu_op;
    logic [RW-1:0] retired;

    int vec = 0;
    int errs = 0;
    logic [RW-1:0] exp_ret;

    multicycle_control_unit #(.ALU_OP_W(AW), .RET_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .if_ready(if_ready), .dm_ready(dm_ready),
        .if_req(if_req), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .next_pc_sel(next_pc_sel), .seu_en(seu_en),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .dw_sel(dw_sel),
        .rw_sel(rw_sel), .rf_wr(rf_wr), .dm_rd(dm_rd),
        .dm_wr(dm_wr), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic int m_lat(input logic [5:0] op);
        case (op)
            6'b000100, 6'b000010: return 3;
            6'b100011:            return 5;
            default:              return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_alu(input logic [5:0] op,
                                         input logic [5:0] fn);
        if (op == 6'b000100) return 4'd1;
        if (op != 6'b000000) return 4'd0;
        case (fn)
            6'b100010: return 4'd1;
            6'b100100: return 4'd2;
            6'b100101: return 4'd3;
            6'b101010: return 4'd4;
            default:   return 4'd0;
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        if_ready = 1'b0;
        dm_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int iw, input int dw,
                             input logic zv, input string nm);
        int n, fcnt, mcnt, nrf, npc, nir, nrd, nwr, nseu, nill, rf_at, g;
        bit other, done;
        logic [3:0] aor;
        logic [1:0] dws, rws, nps;
        int elat, erf, epc, erd, ewr, eseu;
        logic [1:0] edw, erw, enps;
        bit is_lw, is_sw, is_r, is_addi, is_jal, is_j, is_beq;
        n = 0; fcnt = 0; mcnt = 0; nrf = 0; npc = 0; nir = 0;
        nrd = 0; nwr = 0; nseu = 0; nill = 0; rf_at = 0;
        other = 0; done = 0; aor = '0;
        dws = '0; rws = '0; nps = '0;
        g = 0;
        while (!if_req && g < 10) begin
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < 60; k++) begin
            if (n > 0 && if_req && other) begin
                done = 1;
                break;
            end
            zero = zv;
            if (if_req) if_ready = (fcnt == iw);
            else if_ready = 1'($urandom);
            opcode = (if_req && if_ready) ? op : 6'($urandom);
            funct  = (if_req && if_ready) ? fn : 6'($urandom);
            if (dm_rd || dm_wr) dm_ready = (mcnt == dw);
            else dm_ready = 1'($urandom);
            #1;
            n++;
            if (if_req) fcnt++;
            else other = 1;
            if (dm_rd) nrd++;
            if (dm_wr) nwr++;
            if (dm_rd || dm_wr) mcnt++;
            if (rf_wr) begin
                nrf++;
                rf_at = n;
                dws = dw_sel;
                rws = rw_sel;
            end
            if (pc_wr) begin
                npc++;
                nps = next_pc_sel;
            end
            if (ir_wr) nir++;
            if (seu_en) nseu++;
            if (illegal) nill++;
            aor = aor | alu_op;
            @(negedge clk);
        end
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_r    = (op == 6'b000000);
        is_addi = (op == 6'b001000);
        is_jal  = (op == 6'b000011);
        is_j    = (op == 6'b000010);
        is_beq  = (op == 6'b000100);
        elat = m_lat(op) + iw + ((is_lw || is_sw) ? dw : 0);
        erf  = (is_r || is_addi || is_lw || is_jal) ? 1 : 0;
        epc  = 1 + ((is_j || is_jal || (is_beq && zv)) ? 1 : 0);
        enps = (is_j || is_jal) ? 2'b10 : (is_beq && zv) ? 2'b01 : 2'b00;
        erd  = is_lw ? dw + 1 : 0;
        ewr  = is_sw ? dw + 1 : 0;
        eseu = (is_lw || is_sw || is_addi) ? 1 : 0;
        edw  = is_lw ? 2'b01 : is_jal ? 2'b10 : 2'b00;
        erw  = is_r ? 2'b01 : is_jal ? 2'b10 : 2'b00;
        exp_ret = exp_ret + 1'b1;
        vec++;
        if (!done) begin
            errs++;
            $display("FAIL %s timeout: no next fetch after %0d cycles", nm, n);
        end
        vec++;
        if (n !== elat) begin
            errs++;
            $display("FAIL %s cycles got %0d want %0d", nm, n, elat);
        end
        vec++;
        if (nrf !== erf || (erf == 1 && rf_at !== elat)) begin
            errs++;
            $display("FAIL %s rf_wr got %0d@%0d want %0d@%0d",
                     nm, nrf, rf_at, erf, elat);
        end
        vec++;
        if (erf == 1 && {dws, rws} !== {edw, erw}) begin
            errs++;
            $display("FAIL %s dw/rw got %b/%b want %b/%b",
                     nm, dws, rws, edw, erw);
        end
        vec++;
        if (npc !== epc || nps !== enps || nir !== 1) begin
            errs++;
            $display("FAIL %s pc_wr got %0d sel %b ir %0d want %0d sel %b ir 1",
                     nm, npc, nps, nir, epc, enps);
        end
        vec++;
        if (nrd !== erd || nwr !== ewr) begin
            errs++;
            $display("FAIL %s dm rd/wr got %0d/%0d want %0d/%0d",
                     nm, nrd, nwr, erd, ewr);
        end
        vec++;
        if (aor !== m_alu(op, fn) || nseu !== eseu) begin
            errs++;
            $display("FAIL %s alu_op/seu got %b/%0d want %b/%0d",
                     nm, aor, nseu, m_alu(op, fn), eseu);
        end
        vec++;
        if (retired !== exp_ret || nill !== 0) begin
            errs++;
            $display("FAIL %s retired got %0d ill %0d want %0d ill 0",
                     nm, retired, nill, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_ready = 1'b1;
        dm_ready = 1'b1;
        zero = 1'b1;
        opcode = '0;
        funct = '0;
        #2;
        vec++;
        if ({if_req, ir_wr, pc_wr, next_pc_sel, seu_en, alu_src_b, alu_op,
             dw_sel, rw_sel, rf_wr, dm_rd, dm_wr, illegal, retired} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got nonzero want all 0 (retired %0d)",
                     retired);
        end
        @(negedge clk);
        rst = 1'b0;
        if_ready = 1'b0;
        dm_ready = 1'b0;
        exp_ret = '0;
        #1;
        vec++;
        if (if_req !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle if_req got %b want 0", if_req);
        end
        @(negedge clk);
        vec++;
        if (if_req !== 1'b1) begin
            errs++;
            $display("FAIL reset_fetch if_req got %b want 1", if_req);
        end
    endtask

    task automatic test_add();
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, "add");
    endtask

    task automatic test_lw_wait();
        run_instr(6'b100011, 6'($urandom), 0, 3, 1'b0, "lw_wait");
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'($urandom), 0, 0, 1'b1, "beq_taken");
        run_instr(6'b000100, 6'($urandom), 0, 0, 1'b0, "beq_not_taken");
    endtask

    task automatic test_jal();
        run_instr(6'b000011, 6'($urandom), 0, 0, 1'b0, "jal");
    endtask

    task automatic test_random(input int cnt);
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b000011};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < cnt; i++) begin
            op = ops[$urandom_range(0, 6)];
            fn = (op == 6'b000000) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), "random");
        end
    endtask

    task automatic test_trap(input logic [5:0] op, input logic [5:0] fn,
                             input string nm);
        int g;
        g = 0;
        while (!if_req && g < 10) begin
            @(negedge clk);
            g++;
        end
        if_ready = 1'b1;
        opcode = op;
        funct = fn;
        @(negedge clk);
        for (int c = 0; c < 21; c++) begin
            if_ready = 1'($urandom);
            dm_ready = 1'($urandom);
            zero = 1'($urandom);
            opcode = 6'($urandom);
            funct = 6'($urandom);
            @(negedge clk);
            #1;
            vec++;
            if (illegal !== 1'b1 || retired !== exp_ret ||
                {if_req, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr} !== 6'b0) begin
                errs++;
                $display("FAIL %s cycle %0d ill %b ret %0d strobes %b want 1 %0d 0",
                         nm, c, illegal, retired, exp_ret,
                         {if_req, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr});
            end
        end
        rst = 1'b1;
        #1;
        vec++;
        if (illegal !== 1'b0 || retired !== '0) begin
            errs++;
            $display("FAIL %s_clear ill %b ret %0d want 0 0", nm, illegal, retired);
        end
        @(negedge clk);
        rst = 1'b0;
        if_ready = 1'b0;
        dm_ready = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_reset_mid_mem();
        int g;
        g = 0;
        while (!if_req && g < 10) begin
            @(negedge clk);
            g++;
        end
        if_ready = 1'b1;
        opcode = 6'b101011;
        funct = 6'($urandom);
        dm_ready = 1'b0;
        @(negedge clk);
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (dm_wr !== 1'b1) begin
            errs++;
            $display("FAIL sw_mem dm_wr got %b want 1", dm_wr);
        end
        rst = 1'b1;
        #1;
        vec++;
        if (dm_wr !== 1'b0 || retired !== '0) begin
            errs++;
            $display("FAIL rst_mid_mem dm_wr %b ret %0d want 0 0", dm_wr, retired);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = '0;
        @(negedge clk);
        vec++;
        if (if_req !== 1'b0) begin
            errs++;
            $display("FAIL rst_release_idle if_req got %b want 0", if_req);
        end
        @(negedge clk);
        vec++;
        if (if_req !== 1'b1) begin
            errs++;
            $display("FAIL rst_release_fetch if_req got %b want 1", if_req);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_jal();
        test_random(40);
        test_trap(6'b111111, 6'b000000, "trap_op");
        test_trap(6'b000000, 6'b000001, "trap_funct");
        test_random(10);
        test_reset_mid_mem();
        test_random(5);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
